// File: rtl/booth_mult_pkg.sv
// Shared widths, Booth digit encoding and carry-save helpers for the shared multiplier.
// Digits are recoded from overlapping multiplier bit triplets.
package booth_mult_pkg;

    localparam int unsigned OP_W    = 16;
    localparam int unsigned PROD_W  = 32;
    localparam int unsigned NDIGITS = OP_W / 2;

    typedef enum logic [2:0] {
        BoothZero,
        BoothPos1,
        BoothPos2,
        BoothNeg1,
        BoothNeg2
    } booth_digit_e;

    typedef struct packed {
        logic [PROD_W-1:0] sum;
        logic [PROD_W-1:0] carry;
    } csa_t;

    function automatic booth_digit_e booth_encode(input logic [2:0] trip);
        booth_digit_e d;
        d = BoothZero;
        unique case (trip)
            3'b000, 3'b111: d = BoothZero;
            3'b001, 3'b010: d = BoothPos1;
            3'b011:         d = BoothPos2;
            3'b100:         d = BoothNeg2;
            3'b101, 3'b110: d = BoothNeg1;
        endcase
        return d;
    endfunction

    // Unshifted partial product, sign-extended to the full product width.
    function automatic logic [PROD_W-1:0] booth_pp(input logic [OP_W-1:0] a,
                                                   input booth_digit_e d);
        logic [PROD_W-1:0] a_ext;
        logic [PROD_W-1:0] pp;
        a_ext = {{(PROD_W - OP_W){a[OP_W-1]}}, a};
        case (d)
            BoothPos1: pp = a_ext;
            BoothPos2: pp = a_ext << 1;
            BoothNeg1: pp = -a_ext;
            BoothNeg2: pp = -(a_ext << 1);
            default:   pp = '0;
        endcase
        return pp;
    endfunction

    function automatic csa_t csa(input logic [PROD_W-1:0] x,
                                 input logic [PROD_W-1:0] y,
                                 input logic [PROD_W-1:0] z);
        csa_t r;
        r.sum   = x ^ y ^ z;
        r.carry = ((x & y) | (x & z) | (y & z)) << 1;
        return r;
    endfunction

endpackage

// File: rtl/booth_mult_16x16.sv
// Combinational signed 16x16 multiplier: Booth radix-4 recoding, Wallace-style
// carry-save compressor tree, single final carry-propagate adder.
module booth_mult_16x16
    import booth_mult_pkg::*;
(
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic [PROD_W-1:0] product_o
);

    logic [OP_W:0]       b_ext;
    logic [PROD_W-1:0]   pp [NDIGITS];
    csa_t                l1a, l1b, l2a, l2b, l3, l4;

    assign b_ext = {b_i, 1'b0};

    always_comb begin
        for (int i = 0; i < int'(NDIGITS); i++) begin
            pp[i] = booth_pp(a_i, booth_encode(b_ext[2*i +: 3])) << (2 * i);
        end
    end

    // 8 -> 6 -> 4 -> 3 -> 2 rows.
    always_comb begin
        l1a = csa(pp[0], pp[1], pp[2]);
        l1b = csa(pp[3], pp[4], pp[5]);
        l2a = csa(l1a.sum, l1a.carry, l1b.sum);
        l2b = csa(l1b.carry, pp[6], pp[7]);
        l3  = csa(l2a.sum, l2a.carry, l2b.sum);
        l4  = csa(l3.sum, l3.carry, l2b.carry);
    end

    assign product_o = l4.sum + l4.carry;

endmodule

// File: rtl/mult_rr_arbiter.sv
// Combinational round-robin arbiter: searches req_valid from ptr+1 upward (wrapping)
// and returns a one-hot grant plus its encoded index. Pointer state lives in the parent.
module mult_rr_arbiter
    import booth_mult_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            idx = (int'(ptr) + k) % int'(NREQ);
            if (en && !found && req_valid[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/booth_mult_scheduler.sv
// Shares one signed 16x16 multiplier among NREQ requesters through a 2-stage pipeline
// with round-robin admission; the whole pipe stalls when the result is not taken.
module booth_mult_scheduler
    import booth_mult_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ID_W-1:0]      res_id,
    output logic [PROD_W-1:0]    res_product,
    output logic                 busy
);

    logic              v1_q, v1_d;
    logic [ID_W-1:0]   id1_q, id1_d;
    logic [OP_W-1:0]   a1_q, a1_d;
    logic [OP_W-1:0]   b1_q, b1_d;
    logic              v2_q, v2_d;
    logic [ID_W-1:0]   id2_q, id2_d;
    logic [PROD_W-1:0] p2_q, p2_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;

    logic              advance;
    logic              arb_en;
    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   grant_idx;
    logic              granted;
    logic [PROD_W-1:0] mult_p;

    assign advance = !v2_q || res_ready;
    // Reset gates the grant so req_ready drops immediately on an asynchronous reset.
    assign arb_en  = advance & sys_rst_n;
    assign granted = |grant;

    mult_rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    booth_mult_16x16 u_mult (
        .a_i       (a1_q),
        .b_i       (b1_q),
        .product_o (mult_p)
    );

    always_comb begin
        v1_d  = v1_q;
        id1_d = id1_q;
        a1_d  = a1_q;
        b1_d  = b1_q;
        v2_d  = v2_q;
        id2_d = id2_q;
        p2_d  = p2_q;
        ptr_d = ptr_q;
        if (advance) begin
            v1_d  = granted;
            id1_d = grant_idx;
            a1_d  = req_a[grant_idx*OP_W +: OP_W];
            b1_d  = req_b[grant_idx*OP_W +: OP_W];
            v2_d  = v1_q;
            id2_d = id1_q;
            p2_d  = mult_p;
            if (granted) begin
                ptr_d = grant_idx;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            v1_q  <= 1'b0;
            id1_q <= '0;
            a1_q  <= '0;
            b1_q  <= '0;
            v2_q  <= 1'b0;
            id2_q <= '0;
            p2_q  <= '0;
            ptr_q <= ID_W'(NREQ - 1);
        end else begin
            v1_q  <= v1_d;
            id1_q <= id1_d;
            a1_q  <= a1_d;
            b1_q  <= b1_d;
            v2_q  <= v2_d;
            id2_q <= id2_d;
            p2_q  <= p2_d;
            ptr_q <= ptr_d;
        end
    end

    assign req_ready   = grant;
    assign res_valid   = v2_q;
    assign res_id      = id2_q;
    assign res_product = p2_q;
    assign busy        = v1_q | v2_q;

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Randomised scoreboard bench for booth_mult_scheduler: a reference model predicts
// grants from the round-robin rule and products from plain signed arithmetic.
module tb_booth_mult_scheduler;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic                 sys_clk;
    logic                 sys_rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*16-1:0]   req_a;
    logic [NREQ*16-1:0]   req_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [ID_W-1:0]      res_id;
    logic [31:0]          res_product;
    logic                 busy;

    booth_mult_scheduler #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .res_product (res_product),
        .busy        (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard and reference state, owned by the monitor.
    int        sb_id[$];
    int        sb_p[$];
    bit        m_v1, m_v2;
    int        m_ptr = NREQ - 1;
    bit        prev_stall;
    logic [31:0] prev_id, prev_p;
    bit        drain_chk  = 1'b0;
    bit        drain_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    always begin
        @(negedge sys_clk or negedge sys_rst_n);
        if (!sys_rst_n) begin
            #1;
            chk("rst_res_valid", 32'(res_valid), 32'd0);
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_res_id", 32'(res_id), 32'd0);
            chk("rst_res_product", res_product, 32'd0);
            sb_id.delete();
            sb_p.delete();
            m_v1 = 1'b0;
            m_v2 = 1'b0;
            m_ptr = NREQ - 1;
            prev_stall = 1'b0;
        end else begin
            bit adv;
            int gi;
            logic [NREQ-1:0] exp_grant;
            if (res_valid && prev_stall) begin
                chk("stall_stable_id", 32'(res_id), prev_id);
                chk("stall_stable_product", res_product, prev_p);
            end
            chk("res_valid", 32'(res_valid), 32'(m_v2));
            chk("busy", 32'(busy), 32'(m_v1 | m_v2));
            if (res_valid && res_ready) begin
                if (sb_id.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected: got id %0d product %0h, expected no result",
                             res_id, res_product);
                end else begin
                    chk("res_id", 32'(res_id), 32'(sb_id.pop_front()));
                    chk("res_product", res_product, 32'(sb_p.pop_front()));
                end
            end
            prev_stall = res_valid && !res_ready;
            prev_id = 32'(res_id);
            prev_p = res_product;

            adv = !m_v2 || res_ready;
            gi = -1;
            exp_grant = '0;
            if (adv) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int j;
                    j = (m_ptr + k) % NREQ;
                    if (gi < 0 && req_valid[j]) gi = j;
                end
            end
            if (gi >= 0) exp_grant[gi] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_grant));
            if (adv) begin
                m_v2 = m_v1;
                m_v1 = (gi >= 0);
                if (gi >= 0) begin
                    int pa, pb;
                    pa = int'($signed(req_a[16*gi +: 16]));
                    pb = int'($signed(req_b[16*gi +: 16]));
                    sb_id.push_back(gi);
                    sb_p.push_back(pa * pb);
                    m_ptr = gi;
                end
            end
            if (drain_chk && !drain_done) begin
                chk("sb_drained", 32'(sb_id.size()), 32'd0);
                drain_done = 1'b1;
            end
        end
    end

    // Stimulus state.
    int          remaining[NREQ];
    logic [15:0] fix_a[NREQ];
    logic [15:0] fix_b[NREQ];
    bit          use_fixed, dense, rr_random, hook1;
    int          tcount, stall_at, stall_len;
    logic [NREQ-1:0] acc;

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h7fff;
            2: return 16'h0000;
            3: return 16'hffff;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic load(input int i);
        if (use_fixed) begin
            req_a[16*i +: 16] = fix_a[i];
            req_b[16*i +: 16] = fix_b[i];
        end else begin
            req_a[16*i +: 16] = rand_op();
            req_b[16*i +: 16] = rand_op();
        end
    endtask

    task automatic raise();
        for (int i = 0; i < NREQ; i++) begin
            if (remaining[i] > 0 && !req_valid[i] && (dense || $urandom_range(0, 1) == 1)) begin
                load(i);
                req_valid[i] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
        acc = req_valid & req_ready;
        @(posedge sys_clk);
        #1;
        tcount++;
        if (rr_random) res_ready = ($urandom_range(0, 3) != 0);
        else res_ready = !(tcount > stall_at && tcount <= stall_at + stall_len);
    endtask

    task automatic service();
        tick();
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                remaining[i]--;
                req_valid[i] = 1'b0;
                if (i == 0 && hook1) begin
                    remaining[1] = 2;
                    hook1 = 1'b0;
                end
            end
        end
        raise();
    endtask

    function automatic bit any_remaining();
        for (int i = 0; i < NREQ; i++) if (remaining[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run(input int budget);
        int n;
        n = 0;
        raise();
        while (any_remaining()) begin
            service();
            n++;
            if (n > budget) begin
                $display("FAIL run_timeout: got %0d cycles, expected at most %0d", n, budget);
                $fatal(1, "stimulus stuck");
            end
        end
    endtask

    task automatic release_reset();
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        res_ready = 1'b1;
        use_fixed = 1'b1;
        dense = 1'b1;
        rr_random = 1'b0;
        hook1 = 1'b0;
        tcount = 0;
        stall_at = 1000000;
        stall_len = 0;
        for (int i = 0; i < NREQ; i++) begin
            remaining[i] = 0;
            fix_a[i] = '0;
            fix_b[i] = '0;
        end
        repeat (2) @(negedge sys_clk);
        release_reset();

        // Single request from requester 2: 3 * -5.
        fix_a[2] = 16'd3;
        fix_b[2] = 16'hfffb;
        remaining[2] = 1;
        run(20);
        repeat (3) service();

        // All requesters continuously: a = i+1, b = 100.
        for (int i = 0; i < NREQ; i++) begin
            fix_a[i] = 16'(i + 1);
            fix_b[i] = 16'd100;
            remaining[i] = 3;
        end
        run(40);
        repeat (3) service();

        // Corner operands through requester 0.
        for (int c = 0; c < 4; c++) begin
            logic [15:0] ca[4];
            logic [15:0] cb[4];
            ca = '{16'h8000, 16'h7fff, 16'h0000, 16'hffff};
            cb = '{16'h8000, 16'h8000, 16'hffff, 16'hffff};
            fix_a[0] = ca[c];
            fix_b[0] = cb[c];
            remaining[0] = 1;
            run(20);
        end
        repeat (3) service();

        // Backpressure: 20 random ops from requester 1, 3-cycle stall mid-stream.
        use_fixed = 1'b0;
        remaining[1] = 20;
        stall_at = tcount + 6;
        stall_len = 3;
        run(80);
        repeat (4) service();

        // Fairness between 0 and 3, then requester 1 joins after a grant to 0.
        remaining[0] = 4;
        remaining[3] = 4;
        hook1 = 1'b1;
        run(60);
        repeat (3) service();

        // Random traffic with random backpressure.
        rr_random = 1'b1;
        dense = 1'b0;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NREQ; i++) remaining[i] = $urandom_range(0, 6);
            run(600);
        end
        rr_random = 1'b0;
        dense = 1'b1;
        repeat (4) service();

        // Asynchronous reset with two results in flight.
        remaining[0] = 5;
        raise();
        service();
        service();
        #3 sys_rst_n = 1'b0;
        #2;
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) remaining[i] = 0;
        repeat (2) @(negedge sys_clk);
        release_reset();
        use_fixed = 1'b1;
        fix_a[0] = 16'd7;
        fix_b[0] = 16'd9;
        fix_a[2] = 16'hfff0;
        fix_b[2] = 16'd3;
        remaining[0] = 1;
        remaining[2] = 1;
        run(20);
        repeat (5) service();

        drain_chk = 1'b1;
        for (int w = 0; w < 10 && !drain_done; w++) @(negedge sys_clk);
        @(posedge sys_clk);
        if (!drain_done) begin
            $display("FAIL drain_timeout: got no drain check, expected one");
            $fatal(1, "drain");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
